// File: rtl/seq_n_bit_comp_if.sv
// Handshake and operand bundle for the digit-serial magnitude comparator.
// The master drives the request and operands; the slave returns status and result.
interface seq_n_bit_comp_if #(
    parameter int N = 8
);
    logic         start;
    logic         sgn;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic         lt;
    logic         gt;
    logic         eq;

    modport master (
        output start, sgn, a, b,
        input  busy, done, lt, gt, eq
    );

    modport slave (
        input  start, sgn, a, b,
        output busy, done, lt, gt, eq
    );
endinterface

// File: rtl/seq_n_bit_comp.sv
// Digit-serial magnitude comparator: walks the operands MSB-first, D bits per
// cycle, and stops at the first differing digit. Signed compares are turned
// into unsigned ones by flipping the sign bit of both operands when latched.
module seq_n_bit_comp #(
    parameter int N = 8,
    parameter int D = 1
) (
    input  logic            clk,
    input  logic            rst,
    seq_n_bit_comp_if.slave cmp
);
    localparam int NDIG  = N / D;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if (N < 2) begin : g_chk_n
            $error("seq_n_bit_comp: N must be at least 2");
        end
        if ((D < 1) || ((N % D) != 0)) begin : g_chk_d
            $error("seq_n_bit_comp: D must divide N");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        CMP
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       a_q, a_d;
    logic [N-1:0]       b_q, b_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               done_q, done_d;
    logic               lt_q, lt_d;
    logic               gt_q, gt_d;
    logic               eq_q, eq_d;
    logic [D-1:0]       dig_a, dig_b;

    // Two's complement order equals unsigned order once the sign bit is inverted.
    function automatic logic [N-1:0] to_offset_binary(input logic [N-1:0] v,
                                                      input logic         s);
        return s ? {~v[N-1], v[N-2:0]} : v;
    endfunction

    assign dig_a = D'(a_q >> (idx_q * D));
    assign dig_b = D'(b_q >> (idx_q * D));

    assign cmp.busy = (state_q == CMP);
    assign cmp.done = done_q;
    assign cmp.lt   = lt_q;
    assign cmp.gt   = gt_q;
    assign cmp.eq   = eq_q;

    // Next-state logic: latch on start, then scan one digit per cycle until resolved.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        lt_d    = lt_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        case (state_q)
            IDLE: begin
                if (cmp.start) begin
                    a_d     = to_offset_binary(cmp.a, cmp.sgn);
                    b_d     = to_offset_binary(cmp.b, cmp.sgn);
                    idx_d   = IDX_W'(NDIG - 1);
                    state_d = CMP;
                end
            end
            CMP: begin
                if (dig_a != dig_b) begin
                    gt_d    = (dig_a > dig_b);
                    lt_d    = (dig_a < dig_b);
                    eq_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (idx_q == '0) begin
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any compare in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
        end
    end
endmodule

// File: tb/tb_seq_n_bit_comp.sv
// Bench for seq_n_bit_comp: a D=2 instance and a D=8 instance, both N=8,
// checked against a scoreboard fed by a $signed/unsigned reference model.
module tb_seq_n_bit_comp;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_n_bit_comp_if #(.N(8)) bus2 ();
    seq_n_bit_comp_if #(.N(8)) bus8 ();

    seq_n_bit_comp #(.N(8), .D(2)) dut2 (.clk(clk), .rst(rst), .cmp(bus2));
    seq_n_bit_comp #(.N(8), .D(8)) dut8 (.clk(clk), .rst(rst), .cmp(bus8));

    typedef struct {
        logic [2:0] res;   // {lt, gt, eq}
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic s, input int d);
        exp_t       e;
        logic       l, g, q;
        logic [7:0] x;
        int         ndig;
        int         mask;
        ndig = 8 / d;
        mask = (1 << d) - 1;
        if (s) begin
            l = ($signed(a) < $signed(b));
            g = ($signed(a) > $signed(b));
        end else begin
            l = (a < b);
            g = (a > b);
        end
        q     = (a == b);
        e.res = {l, g, q};
        x     = a ^ b;
        e.lat = ndig;
        for (int k = ndig - 1; k >= 0; k--) begin
            if ((int'(x >> (k * d)) & mask) != 0) begin
                e.lat = ndig - k;
                break;
            end
        end
        return e;
    endfunction

    task automatic drive_start(input bit sel8, input logic [7:0] a,
                               input logic [7:0] b, input logic s);
        @(negedge clk);
        if (sel8) begin
            bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.sgn = s;
        end else begin
            bus2.start = 1'b1; bus2.a = a; bus2.b = b; bus2.sgn = s;
        end
        exp_q.push_back(model(a, b, s, sel8 ? 8 : 2));
        @(posedge clk);
        #1;
        bus2.start = 1'b0;
        bus8.start = 1'b0;
    endtask

    task automatic wait_done(input bit sel8, output int lat,
                             output logic [2:0] res, output bit to);
        lat = 0;
        to  = 1'b1;
        res = '0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (sel8 ? bus8.done : bus2.done) begin
                res = sel8 ? {bus8.lt, bus8.gt, bus8.eq} : {bus2.lt, bus2.gt, bus2.eq};
                to  = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus2.busy, bus2.done, bus2.lt, bus2.gt, bus2.eq} !== 5'b0) begin
            failures++;
            $display("FAIL reset_d2 got busy,done,lt,gt,eq=%b want 00000",
                     {bus2.busy, bus2.done, bus2.lt, bus2.gt, bus2.eq});
        end
        checks++;
        if ({bus8.busy, bus8.done, bus8.lt, bus8.gt, bus8.eq} !== 5'b0) begin
            failures++;
            $display("FAIL reset_d8 got busy,done,lt,gt,eq=%b want 00000",
                     {bus8.busy, bus8.done, bus8.lt, bus8.gt, bus8.eq});
        end
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        logic [7:0] va[5] = '{8'hA5, 8'h80, 8'h80, 8'h12, 8'hFF};
        logic [7:0] vb[5] = '{8'hA5, 8'h7F, 8'h7F, 8'h13, 8'h01};
        logic       vs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_t       e;
        int         lat;
        logic [2:0] res;
        bit         to;
        for (int i = 0; i < 5; i++) begin
            drive_start(1'b0, va[i], vb[i], vs[i]);
            checks++;
            if (bus2.busy !== 1'b1) begin
                failures++;
                $display("FAIL vec%0d_busy got %b want 1", i, bus2.busy);
            end
            wait_done(1'b0, lat, res, to);
            e = exp_q.pop_front();
            checks++;
            if (to || res !== e.res || lat !== e.lat) begin
                failures++;
                $display("FAIL vec%0d got lt,gt,eq=%b lat=%0d timeout=%0b want %b lat=%0d",
                         i, res, lat, to, e.res, e.lat);
            end
        end
    endtask

    task automatic test_start_held_back_to_back();
        exp_t       e;
        int         lat;
        logic [2:0] res;
        bit         to;
        @(negedge clk);
        bus2.start = 1'b1; bus2.a = 8'h12; bus2.b = 8'h13; bus2.sgn = 1'b0;
        exp_q.push_back(model(8'h12, 8'h13, 1'b0, 2));
        @(posedge clk);
        #1;
        bus2.a = 8'h80; bus2.b = 8'h7F;
        exp_q.push_back(model(8'h80, 8'h7F, 1'b0, 2));
        wait_done(1'b0, lat, res, to);
        e = exp_q.pop_front();
        checks++;
        if (to || res !== e.res || lat !== e.lat) begin
            failures++;
            $display("FAIL held_first got lt,gt,eq=%b lat=%0d timeout=%0b want %b lat=%0d",
                     res, lat, to, e.res, e.lat);
        end
        @(posedge clk);
        #1;
        bus2.start = 1'b0;
        checks++;
        if (bus2.busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_busy got %b want 1", bus2.busy);
        end
        wait_done(1'b0, lat, res, to);
        e = exp_q.pop_front();
        checks++;
        if (to || res !== e.res || lat !== e.lat) begin
            failures++;
            $display("FAIL b2b_second got lt,gt,eq=%b lat=%0d timeout=%0b want %b lat=%0d",
                     res, lat, to, e.res, e.lat);
        end
    endtask

    task automatic test_reset_mid();
        int seen_done;
        @(negedge clk);
        bus2.start = 1'b1; bus2.a = 8'h00; bus2.b = 8'h00; bus2.sgn = 1'b0;
        @(posedge clk);
        #1;
        bus2.start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({bus2.busy, bus2.done, bus2.lt, bus2.gt, bus2.eq} !== 5'b0) begin
            failures++;
            $display("FAIL rst_mid got busy,done,lt,gt,eq=%b want 00000",
                     {bus2.busy, bus2.done, bus2.lt, bus2.gt, bus2.eq});
        end
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus2.done) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            failures++;
            $display("FAIL rst_mid_no_done got %0d done pulses want 0", seen_done);
        end
    endtask

    task automatic test_rst_start();
        @(negedge clk);
        rst = 1'b1;
        bus2.start = 1'b1; bus2.a = 8'h01; bus2.b = 8'h02; bus2.sgn = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus2.start = 1'b0;
        checks++;
        if ({bus2.busy, bus2.done} !== 2'b00) begin
            failures++;
            $display("FAIL rst_start got busy,done=%b want 00", {bus2.busy, bus2.done});
        end
    endtask

    task automatic test_single_digit();
        logic [7:0] va[2] = '{8'h05, 8'h3C};
        logic [7:0] vb[2] = '{8'h09, 8'h3C};
        exp_t       e;
        int         lat;
        logic [2:0] res;
        bit         to;
        for (int i = 0; i < 2; i++) begin
            drive_start(1'b1, va[i], vb[i], 1'b0);
            wait_done(1'b1, lat, res, to);
            e = exp_q.pop_front();
            checks++;
            if (to || res !== e.res || lat !== e.lat) begin
                failures++;
                $display("FAIL d8_vec%0d got lt,gt,eq=%b lat=%0d timeout=%0b want %b lat=%0d",
                         i, res, lat, to, e.res, e.lat);
            end
        end
    endtask

    task automatic test_random();
        exp_t       e;
        int         lat;
        logic [2:0] res;
        bit         to;
        logic [7:0] ra, rb;
        logic       rs;
        bit         sel8;
        for (int i = 0; i < 1200; i++) begin
            sel8 = (i >= 1000);
            ra   = 8'($urandom_range(0, 255));
            rb   = ($urandom_range(0, 3) == 0) ? ra ^ 8'($urandom_range(0, 3))
                                               : 8'($urandom_range(0, 255));
            rs   = 1'($urandom_range(0, 1));
            drive_start(sel8, ra, rb, rs);
            wait_done(sel8, lat, res, to);
            e = exp_q.pop_front();
            checks++;
            if (to || res !== e.res || lat !== e.lat) begin
                failures++;
                $display("FAIL rand%0d d=%0d a=%h b=%h sgn=%b got lt,gt,eq=%b lat=%0d timeout=%0b want %b lat=%0d",
                         i, sel8 ? 8 : 2, ra, rb, rs, res, lat, to, e.res, e.lat);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus2.start = 1'b0; bus2.sgn = 1'b0; bus2.a = '0; bus2.b = '0;
        bus8.start = 1'b0; bus8.sgn = 1'b0; bus8.a = '0; bus8.b = '0;
        test_reset();
        test_vectors();
        test_start_held_back_to_back();
        test_reset_mid();
        test_rst_start();
        test_single_digit();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
        $fatal(1);
    end
endmodule
